fifo_write_arbiter: RTL

Shares one `fifo` instance among `NUM_REQ` write requesters using round-robin, burst-locked arbitration. The read side passes straight through to a single consumer, such as the UART TX engine or a CPU-side data register. A hysteresis watermark flag drives the peripheral interrupt logic. The block sits between multiple producers and a single consumer in the peripherals tree.

---
 rtl/fifo_arb_pkg.sv | 36 +++
 rtl/fifo.sv | 50 +++++
 rtl/fifo_write_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB, OWN} arb_state_t;

    localparam int MAX_REQ       = 8;
    localparam int DFLT_NUM_REQ  = 4;
    localparam int DFLT_TIMEOUT  = 15;
    localparam int PTR_W         = $clog2(DFLT_NUM_REQ);
    localparam int CNT_W         = $clog2(DFLT_TIMEOUT + 1);

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of mask at or after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] mask,
                                      input logic [2:0] ptr, input int n);
        pick_t r;
        int    j;
        r = '0;
        // Walk from the far end so the nearest hit is the one left standing.
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                j = (int'(ptr) + i) % n;
                if (mask[j]) begin
                    r.found = 1'b1;
                    r.idx   = 3'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with combinational head and occupancy count.
module fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   write,
    input  logic [WIDTH-1:0]       write_data,
    input  logic                   read,
    output logic [WIDTH-1:0]       read_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_write, do_read;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    // A write into a full FIFO is dropped even if a pop frees a slot.
    assign do_write  = write && !full;
    assign do_read   = read && !empty;
    assign read_data = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_write) mem[wr_ptr] <= write_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked write arbitration of NUM_REQ producers into one
// FIFO, with idle/disable release and a hysteresis watermark flag.
module fifo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int HIGH_WM = 12,
    parameter int LOW_WM  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_last,
    input  logic [NUM_REQ*WIDTH-1:0]    i_req_data,
    input  logic [NUM_REQ-1:0]          i_req_enable,
    output logic [NUM_REQ-1:0]          o_req_ready,
    input  logic                        i_read,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [$clog2(NUM_REQ)-1:0]  o_owner,
    output logic                        o_busy,
    output logic                        o_wm_high,
    output logic                        o_abort
);
    import fifo_arb_pkg::*;

    localparam int SEL_W  = $clog2(NUM_REQ);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int CW     = $clog2(DEPTH) + 1;

    arb_state_t        state;
    logic [SEL_W-1:0]  owner, rr_ptr, owner_inc;
    logic [IDLE_W-1:0] idle_cnt;
    logic              full, own_valid, own_last, own_enable, can_accept, accept;
    logic [WIDTH-1:0]  wr_data;
    pick_t             pick;

    assign own_valid  = i_req_valid[owner];
    assign own_last   = i_req_last[owner];
    assign own_enable = i_req_enable[owner];
    assign wr_data    = i_req_data[owner*WIDTH +: WIDTH];
    assign owner_inc  = (owner == SEL_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // A disabled owner sees ready low, so nothing is written in its release cycle.
    assign can_accept  = (state == OWN) && own_enable && !full;
    assign o_req_ready = can_accept ? (NUM_REQ'(1) << owner) : '0;
    assign accept      = can_accept && own_valid;

    assign pick    = rr_pick(MAX_REQ'(i_req_valid & i_req_enable), 3'(rr_ptr), NUM_REQ);
    assign o_busy  = (state == OWN);
    assign o_owner = owner;

    fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .write      (accept),
        .write_data (wr_data),
        .read       (i_read),
        .read_data  (o_data),
        .full       (full),
        .empty      (o_empty),
        .count      (o_count)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ARB;
            owner    <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
            o_abort  <= 1'b0;
        end else begin
            o_abort <= 1'b0;
            case (state)
                ARB: begin
                    if (pick.found) begin
                        state    <= OWN;
                        owner    <= SEL_W'(pick.idx);
                        idle_cnt <= '0;
                    end
                end
                OWN: begin
                    if (!own_enable) begin
                        state    <= ARB;
                        rr_ptr   <= owner_inc;
                        idle_cnt <= '0;
                        o_abort  <= 1'b1;
                    end else if (accept && own_last) begin
                        state    <= ARB;
                        rr_ptr   <= owner_inc;
                        idle_cnt <= '0;
                    end else if (own_valid) begin
                        // Valid held against a full FIFO is not idle time.
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
                        state    <= ARB;
                        rr_ptr   <= owner_inc;
                        idle_cnt <= '0;
                        o_abort  <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                     o_wm_high <= 1'b0;
        else if (o_count >= CW'(HIGH_WM))   o_wm_high <= 1'b1;
        else if (o_count <= CW'(LOW_WM))    o_wm_high <= 1'b0;
    end

endmodule
